// File: rtl/axi_lite_master.sv
// Single-outstanding initiator for the 5-channel rdy/ack memory interface.
// Accepts one local command, drives aw/w or ar, and returns b/r (or a watchdog abort) on the rsp port.
module axi_lite_master #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_rdy,
  output logic          cmd_ack,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          aw_rdy,
  input  logic          aw_ack,
  output logic [AW-1:0] aw,
  output logic          w_rdy,
  input  logic          w_ack,
  output logic [DW-1:0] w,
  input  logic          b_rdy,
  output logic          b_ack,
  input  logic [1:0]    b,
  output logic          ar_rdy,
  input  logic          ar_ack,
  output logic [AW-1:0] ar,
  input  logic          r_rdy,
  output logic          r_ack,
  input  logic [DW-1:0] r,
  output logic          rsp_rdy,
  input  logic          rsp_ack,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_resp,
  output logic          rsp_timeout,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] rd_cnt
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t         state;
  logic [WDW-1:0] wd;
  logic           wait_st;
  logic           advance;
  logic           expire;
  logic           is_wr;

  // cmd_ack is forced low while reset is held so every rdy/ack reads 0 in reset.
  assign cmd_ack = rst && (state == IDLE);
  assign b_ack   = (state == WR_RESP);
  assign r_ack   = (state == RD_DATA);
  assign wait_st = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_DATA);
  assign is_wr   = (state == WR_REQ) || (state == WR_RESP);
  assign expire  = (TIMEOUT != 0) && (wd == WD_LAST);

  // aw/w are finished once their rdy has dropped or they handshake this edge.
  always_comb begin
    advance = 1'b0;
    case (state)
      WR_REQ:  advance = (!aw_rdy || aw_ack) && (!w_rdy || w_ack);
      WR_RESP: advance = b_rdy;
      RD_REQ:  advance = ar_ack;
      RD_DATA: advance = r_rdy;
      default: advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wd          <= '0;
      aw_rdy      <= 1'b0;
      w_rdy       <= 1'b0;
      ar_rdy      <= 1'b0;
      aw          <= '0;
      w           <= '0;
      ar          <= '0;
      rsp_rdy     <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
    end else if (wait_st && !advance && expire) begin
      // Watchdog abort: a handshake completing on this edge would have won instead.
      aw_rdy      <= 1'b0;
      w_rdy       <= 1'b0;
      ar_rdy      <= 1'b0;
      rsp_rdy     <= 1'b1;
      rsp_write   <= is_wr;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b11;
      rsp_timeout <= 1'b1;
      if (is_wr) wr_cnt <= wr_cnt + 1'b1;
      else       rd_cnt <= rd_cnt + 1'b1;
      state       <= RSP;
    end else begin
      if (wait_st) wd <= wd + 1'b1;
      case (state)
        IDLE: begin
          if (cmd_rdy) begin
            wd <= '0;
            if (cmd_write) begin
              aw     <= cmd_addr;
              w      <= cmd_wdata;
              aw_rdy <= 1'b1;
              w_rdy  <= 1'b1;
              state  <= WR_REQ;
            end else begin
              ar     <= cmd_addr;
              ar_rdy <= 1'b1;
              state  <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_ack) aw_rdy <= 1'b0;
          if (w_ack)  w_rdy  <= 1'b0;
          if (advance) state <= WR_RESP;
        end
        WR_RESP: begin
          if (b_rdy) begin
            rsp_rdy   <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= b;
            wr_cnt    <= wr_cnt + 1'b1;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (ar_ack) begin
            ar_rdy <= 1'b0;
            state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_rdy) begin
            rsp_rdy   <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= r;
            rsp_resp  <= 2'b00;
            rd_cnt    <= rd_cnt + 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ack) begin
            rsp_rdy     <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
Initiator for the team's 5-channel rdy/ack AXI-style memory interface (aw, w, b, ar, r). It accepts single read/write commands from a local command port and drives the address/data channels. It collects the b or r response and returns it on a local response port. It sits in front of any responder on that interface. One transaction is in flight at a time. A per-transaction watchdog guarantees forward progress.

Parameters:
AW, 6, address width (aw, ar, cmd_addr)
DW, 32, data width (w, r, cmd_wdata, rsp_rdata)
TIMEOUT, 64, max cycles spent in wait states before abort; 0 disables the watchdog
CW, 16, width of completed-transaction counters

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset
cmd_rdy  in  1  command valid
cmd_ack  out  1  command accepted (transfer = cmd_rdy && cmd_ack)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  target address
cmd_wdata  in  DW  write data
aw_rdy  out  1  write address valid
aw_ack  in  1  responder accepts aw
aw  out  AW  write address
w_rdy  out  1  write data valid
w_ack  in  1  responder accepts w
w  out  DW  write data
b_rdy  in  1  write response valid
b_ack  out  1  master accepts b
b  in  2  write response code
ar_rdy  out  1  read address valid
ar_ack  in  1  responder accepts ar
ar  out  AW  read address
r_rdy  in  1  read data valid
r_ack  out  1  master accepts r
r  in  DW  read data
rsp_rdy  out  1  response valid
rsp_ack  in  1  consumer accepts response
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DW  read data (0 for writes)
rsp_resp  out  2  b code for writes, 0 for reads, 2'b11 on timeout
rsp_timeout  out  1  transaction aborted by watchdog
wr_cnt  out  CW  completed writes (incl. timed out), wraps
rd_cnt  out  CW  completed reads (incl. timed out), wraps

Behaviour:
- Handshake rule on every channel: a beat transfers on the posedge where rdy && ack. The sender holds rdy and data stable until the transfer. rdy deasserts on that same edge unless another beat follows; none does here.
- Reset (rst low, async): state IDLE. All rdy/ack outputs 0, aw/w/ar/rsp_* 0, counters 0, watchdog 0. Reset mid-transaction abandons it silently. No response is produced.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ack=1 (combinational from state only). On transfer, latch addr/data. Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ: aw_rdy and w_rdy both rise on the edge after command transfer. They are tracked independently by done flags. Each drops on its own handshake edge. Aw-first, w-first and simultaneous are all legal. The state exits to WR_RESP on the edge where the last of the two completes.
- WR_RESP: b_ack=1 (combinational from state). On b_rdy: rsp_resp<=b, rsp_write<=1, rsp_rdata<=0, wr_cnt++, go to RSP.
- RD_REQ: ar_rdy=1, ar=latched addr. On ar_ack, go to RD_DATA.
- RD_DATA: r_ack=1. On r_rdy: rsp_rdata<=r, rsp_resp<=0, rsp_write<=0, rd_cnt++, go to RSP.
- RSP: rsp_rdy=1, fields stable. On rsp_ack, go to IDLE. cmd_ack stays 0 until IDLE, so there is no command overlap.
- Minimum latency with an always-ready responder: command edge N, aw/w transfer N+1, b at N+2 or later (responder dependent), rsp_rdy the cycle after the b/r transfer.
- b_ack and r_ack are never asserted outside WR_RESP/RD_DATA. Stray b_rdy/r_rdy elsewhere is ignored.
- Watchdog: the counter clears on entry to WR_REQ/RD_REQ and increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA. When the counter == TIMEOUT-1 and the pending handshake has not completed that edge:
  - drop all channel rdy/ack;
  - set rsp_timeout=1, rsp_resp=2'b11, rsp_rdata=0;
  - increment the matching counter;
  - go to RSP.
  A handshake completing on the same edge as expiry wins; no timeout occurs. rsp_timeout clears on leaving RSP.
- Counters are CW bits wide and wrap modulo 2^CW.

Test Plan:
- Write 0xDEADBEEF to addr 3 against the standard responder -> aw=3/w=0xDEADBEEF transfer one cycle after cmd; rsp_write=1, rsp_resp=0, wr_cnt=1.
- Read addr 3 after the above -> ar=3 transfers; rsp_rdata=0xDEADBEEF, rsp_write=0, rd_cnt=1; read of unwritten addr 5 -> 0.
- Hold aw_ack=0 for 5 cycles with w_ack=1 -> w_rdy drops after 1 cycle; aw_rdy and aw=3 held stable for 5 cycles; exactly one b_ack window follows.
- Hold rsp_ack=0 for 10 cycles -> rsp_* fields stable, cmd_ack=0 throughout; next cmd accepted on the cycle after rsp_ack.
- Responder never raises b_rdy, TIMEOUT=64 -> rsp_rdy at cycle 64 after entering WR_REQ; rsp_resp=2'b11, rsp_timeout=1; b_ack low afterwards.
- Pulse rst low while in RD_DATA -> all outputs 0 asynchronously; FSM in IDLE, cmd_ack=1 after release; no rsp_rdy pulse.
